// File: rtl/apb_bus_arbiter.sv
// Round-robin arbiter that shares one APB slave between NUM_REQ local requesters.
// Each grant runs one SETUP and one ACCESS phase, then pulses done to the winner.
module apb_bus_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      pwrite,
    output logic                      psel,
    output logic                      penable,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic [DATA_W-1:0]  r_rdata;
    logic [ADDR_W-1:0]  r_paddr;
    logic               r_pwrite;
    logic [DATA_W-1:0]  r_pwdata;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic [IDX_W:0]     w_sum   [NUM_REQ];
    logic [IDX_W-1:0]   w_cand  [NUM_REQ];
    logic [ADDR_W-1:0]  w_addr  [NUM_REQ];
    logic [DATA_W-1:0]  w_wdata [NUM_REQ];
    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W-1:0]   w_ptr_next;

    // A requester whose done is high this cycle must re-request before it can win again.
    assign w_elig = req & ~r_done;

    // w_cand[k] is the requester visited k steps after the priority pointer.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_addr[gi]     = req_addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata[gi]    = req_wdata[gi*DATA_W +: DATA_W];
            assign w_sum[gi]      = {1'b0, r_ptr} + (IDX_W+1)'(gi);
            assign w_cand[gi]     = (w_sum[gi] >= (IDX_W+1)'(NUM_REQ))
                                  ? IDX_W'(w_sum[gi] - (IDX_W+1)'(NUM_REQ))
                                  : IDX_W'(w_sum[gi]);
            assign w_grant_oh[gi] = (r_grant == IDX_W'(gi));
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest eligible one wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_elig[w_cand[k]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[k];
            end
        end
    end

    assign w_ptr_next = (w_winner == IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_rdata  <= '0;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_paddr  <= w_addr[w_winner];
                        r_pwrite <= req_write[w_winner];
                        r_pwdata <= w_wdata[w_winner];
                        r_grant  <= w_winner;
                        r_ptr    <= w_ptr_next;
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (!r_pwrite) begin
                        r_rdata <= prdata;
                    end
                    r_done  <= w_grant_oh;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign psel    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign penable = (r_state == ST_ACCESS);
    assign done    = r_done;
    assign rdata   = r_rdata;
    assign paddr   = r_paddr;
    assign pwrite  = r_pwrite;
    assign pwdata  = r_pwdata;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Bench for apb_bus_arbiter: directed vector table, hand-written corner sequences,
// and random traffic checked cycle by cycle against a transaction-level model.
module tb_apb_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    done;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   paddr;
    logic            pwrite;
    logic            psel;
    logic            penable;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata;

    always #5 clk = ~clk;

    apb_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .rdata(rdata),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pwdata(pwdata), .prdata(prdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    // Simple APB slave: storage written in ACCESS, read data driven combinationally.
    logic [31:0] slv_mem [256];
    assign prdata = slv_mem[paddr];

    initial begin
        for (int i = 0; i < 256; i++) slv_mem[i] = '0;
        forever begin
            @(posedge clk);
            if (!rst && psel && penable && pwrite) slv_mem[paddr] = pwdata;
        end
    end

    // Reference model: age of the current transfer in cycles (0 = none in flight).
    logic [31:0] ref_mem [256];
    int          m_age, m_ptr, m_who;
    logic [N-1:0] m_done;
    logic [7:0]  m_addr;
    logic        m_wr;
    logic [31:0] m_wdata, m_rdata;
    bit          m_on;

    task automatic model_step();
        logic [N-1:0] elig;
        logic [N-1:0] nd;
        int w;
        if (rst) begin
            m_age = 0; m_ptr = 0; m_who = 0; m_done = '0;
            m_addr = '0; m_wr = 1'b0; m_wdata = '0; m_rdata = '0;
            m_on = 1'b1;
            return;
        end
        elig = req & ~m_done;
        nd   = '0;
        if (m_age == 0) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) begin
                m_who   = w;
                m_addr  = req_addr[w*AW +: AW];
                m_wr    = req_write[w];
                m_wdata = req_wdata[w*DW +: DW];
                m_ptr   = (w + 1) % N;
                m_age   = 1;
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else begin
            if (m_wr) ref_mem[m_addr] = m_wdata;
            else      m_rdata = ref_mem[m_addr];
            nd[m_who] = 1'b1;
            m_age = 0;
            $display("xfer: requester %0d %s addr=%02h data=%08h", m_who,
                     m_wr ? "write" : "read ", m_addr, m_wr ? m_wdata : m_rdata);
        end
        m_done = nd;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        m_on = 1'b0; m_age = 0; m_ptr = 0; m_who = 0; m_done = '0;
        m_addr = '0; m_wr = 1'b0; m_wdata = '0; m_rdata = '0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_on) begin
                n_cmp++;
                if (psel !== (m_age != 0) || penable !== (m_age == 2) || done !== m_done ||
                    rdata !== m_rdata || paddr !== m_addr || pwrite !== m_wr || pwdata !== m_wdata) begin
                    n_bad++;
                    $display("FAIL model cycle: got psel=%b penable=%b done=%b rdata=%08h paddr=%02h pwrite=%b pwdata=%08h, want psel=%b penable=%b done=%b rdata=%08h paddr=%02h pwrite=%b pwdata=%08h",
                             psel, penable, done, rdata, paddr, pwrite, pwdata,
                             m_age != 0, m_age == 2, m_done, m_rdata, m_addr, m_wr, m_wdata);
                end
            end
        end
    end

    typedef struct {
        bit              do_rst;
        logic [2:0]      rq;
        logic [2:0]      wr;
        logic [2:0][7:0] addr;
        logic [2:0][31:0] wd;
        int              n_exp;
        logic [1:0][1:0] ord;
        logic [1:0][31:0] rd;
    } vec_t;

    function automatic vec_t mk(input bit r, input logic [2:0] rq, input logic [2:0] wr,
                                input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input int n, input logic [1:0] o0, input logic [1:0] o1,
                                input logic [31:0] r0, input logic [31:0] r1);
        vec_t v;
        v.do_rst = r; v.rq = rq; v.wr = wr;
        v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
        v.wd[0] = d0; v.wd[1] = d1; v.wd[2] = d2;
        v.n_exp = n; v.ord[0] = o0; v.ord[1] = o1; v.rd[0] = r0; v.rd[1] = r1;
        return v;
    endfunction

    function automatic int done_idx(input logic [N-1:0] d);
        int idx = -1;
        for (int i = 0; i < N; i++)
            if (d[i]) idx = (idx == -1) ? i : 99;
        return idx;
    endfunction

    // Each requester drops req in the cycle its done is seen; done spacing must be 3 cycles.
    task automatic run_vec(input vec_t v, input string tag);
        int got, cyc, idx, last;
        if (v.do_rst) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            req_write[i]          = v.wr[i];
            req_addr[i*AW +: AW]  = v.addr[i];
            req_wdata[i*DW +: DW] = v.wd[i];
        end
        req = v.rq;
        got = 0; cyc = 0; last = 0;
        while (got < v.n_exp && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done != '0) begin
                idx = done_idx(done);
                chk({tag, " order"}, 32'(idx), 32'(v.ord[got]));
                chk({tag, " rdata"}, rdata, v.rd[got]);
                chk({tag, " latency"}, 32'(cyc - last), 32'd3);
                last = cyc;
                if (idx >= 0 && idx < N) req[idx] = 1'b0;
                got++;
            end
        end
        if (got < v.n_exp) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: got %0d dones, want %0d", tag, got, v.n_exp);
        end
        req = '0;
    endtask

    vec_t tbl [7];
    int   fair_ord [4];
    int   fcnt [N];

    initial begin
        int got, cyc, idx, last, prev;
        rst = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset psel", 32'(psel), 32'd0);
        chk("reset penable", 32'(penable), 32'd0);
        chk("reset pwrite", 32'(pwrite), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset paddr", 32'(paddr), 32'd0);
        chk("reset pwdata", pwdata, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Write 0x61 to 0x32; inputs changed after the grant edge must be ignored.
        req_write[0] = 1'b1; req_addr[7:0] = 8'h32; req_wdata[31:0] = 32'h61; req[0] = 1'b1;
        @(negedge clk);
        chk("t1 setup psel", 32'(psel), 32'd1);
        chk("t1 setup penable", 32'(penable), 32'd0);
        chk("t1 setup paddr", 32'(paddr), 32'h32);
        chk("t1 setup done", 32'(done), 32'd0);
        req[0] = 1'b0; req_addr[7:0] = 8'h77;
        @(negedge clk);
        chk("t1 access psel", 32'(psel), 32'd1);
        chk("t1 access penable", 32'(penable), 32'd1);
        chk("t1 access paddr", 32'(paddr), 32'h32);
        chk("t1 access pwdata", pwdata, 32'h61);
        chk("t1 access pwrite", 32'(pwrite), 32'd1);
        @(negedge clk);
        chk("t1 done", 32'(done), 32'b001);
        chk("t1 idle psel", 32'(psel), 32'd0);
        chk("t1 rdata", rdata, 32'd0);

        tbl[0] = mk(0, 3'b001, 3'b000, 8'h32, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 32'h61, 0);
        tbl[1] = mk(1, 3'b011, 3'b011, 8'h10, 8'h11, 8'h00, 32'h99, 32'h55, 0, 2, 0, 1, 0, 0);
        tbl[2] = mk(0, 3'b011, 3'b000, 8'h10, 8'h11, 8'h00, 0, 0, 0, 2, 0, 1, 32'h99, 32'h55);
        tbl[3] = mk(0, 3'b101, 3'b100, 8'h10, 8'h00, 8'h20, 0, 0, 32'hab, 2, 2, 0, 32'h55, 32'h99);
        tbl[4] = mk(0, 3'b010, 3'b000, 8'h00, 8'h32, 8'h00, 0, 0, 0, 1, 1, 0, 32'h61, 0);
        tbl[5] = mk(0, 3'b001, 3'b001, 8'h32, 8'h00, 8'h00, 32'hff, 0, 0, 1, 0, 0, 32'h61, 0);
        tbl[6] = mk(0, 3'b100, 3'b000, 8'h00, 8'h00, 8'h32, 0, 0, 0, 1, 2, 0, 32'hff, 0);
        for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Two requesters held high across four transfers must alternate.
        fair_ord[0] = 0; fair_ord[1] = 1; fair_ord[2] = 0; fair_ord[3] = 1;
        for (int i = 0; i < N; i++) fcnt[i] = 0;
        @(negedge clk);
        req_write[1:0] = 2'b11;
        req_addr[7:0] = 8'h40; req_addr[15:8] = 8'h41;
        req_wdata[31:0] = 32'h1; req_wdata[63:32] = 32'h2;
        req = 3'b011;
        got = 0; cyc = 0; last = 0; prev = -1;
        while (got < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done != '0) begin
                idx = done_idx(done);
                chk("fair order", 32'(idx), 32'(fair_ord[got]));
                chk("fair gap", 32'(cyc - last), 32'd3);
                chk("fair repeat", 32'(idx == prev), 32'd0);
                if (idx >= 0 && idx < N) begin
                    fcnt[idx]++;
                    if (fcnt[idx] == 2) req[idx] = 1'b0;
                end
                prev = idx; last = cyc; got++;
            end
        end
        if (got < 4) begin
            n_cmp++; n_bad++;
            $display("FAIL fair timeout: got %0d dones, want 4", got);
        end
        req = '0;

        // Reset during ACCESS aborts the write and returns the pointer to 0.
        @(negedge clk);
        req_write[0] = 1'b1; req_addr[7:0] = 8'h00; req_wdata[31:0] = 32'hffff_ffff; req = 3'b001;
        @(negedge clk);
        @(negedge clk);
        chk("t4 in access", 32'(penable), 32'd1);
        rst = 1'b1; req = '0;
        @(negedge clk);
        chk("t4 psel", 32'(psel), 32'd0);
        chk("t4 penable", 32'(penable), 32'd0);
        chk("t4 done", 32'(done), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4 no done", 32'(done), 32'd0);
        end
        run_vec(mk(0, 3'b011, 3'b000, 8'h00, 8'h32, 8'h00, 0, 0, 0, 2, 0, 1, 32'h0, 32'hff), "t4 after");

        // Random traffic; the model checker compares every cycle.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst = ($urandom_range(249, 0) == 0);
            for (int i = 0; i < N; i++) begin
                if (done[i]) begin
                    if ($urandom_range(1, 0) == 0) begin
                        req[i] = 1'b0;
                    end else begin
                        req_write[i]          = 1'($urandom_range(1, 0));
                        req_addr[i*AW +: AW]  = 8'($urandom_range(15, 0));
                        req_wdata[i*DW +: DW] = $urandom;
                    end
                end else if (!req[i] && $urandom_range(3, 0) == 0) begin
                    req_write[i]          = 1'($urandom_range(1, 0));
                    req_addr[i*AW +: AW]  = 8'($urandom_range(15, 0));
                    req_wdata[i*DW +: DW] = $urandom;
                    req[i] = 1'b1;
                end
            end
        end
        rst = 1'b0; req = '0;
        repeat (6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
